data_mem_stage: RTL and testbench



---
 rtl/data_mem_stage.sv | 151 +++++++++++++++
 tb/tb_data_mem_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_stage.sv
// MIPS MEM stage: byte/half/word loads and stores on an internal byte-addressed memory, 1-cycle MEM/WB register.
// Latency 1 cycle; no handshake, i_stall freezes MEM/WB and blocks writes, i_valid=0 inserts a bubble.
module data_mem_stage #(
  parameter int NB_DATA     = 32,
  parameter int NB_ADDR     = 8,
  parameter int NB_CTRL_WB  = 2,
  parameter int NB_CTRL_MEM = 7,
  parameter int NB_REG      = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic                   i_stall,
  input  logic [NB_CTRL_MEM-1:0] i_ctrl_mem,
  input  logic [NB_CTRL_WB-1:0]  i_ctrl_wb,
  input  logic [NB_DATA-1:0]     i_alu_result,
  input  logic [NB_DATA-1:0]     i_store_data,
  input  logic [NB_REG-1:0]      i_rd_addr,
  input  logic [NB_ADDR-1:0]     i_debug_addr,
  output logic                   o_valid,
  output logic [NB_CTRL_WB-1:0]  o_ctrl_wb,
  output logic [NB_DATA-1:0]     o_read_data,
  output logic [NB_DATA-1:0]     o_alu_result,
  output logic [NB_REG-1:0]      o_rd_addr,
  output logic                   o_misaligned,
  output logic [NB_DATA-1:0]     o_debug_data
);

  localparam int NB_LANE = NB_DATA / 8;
  localparam int DEPTH   = 2 ** NB_ADDR;

  logic [NB_DATA-1:0] mem_q [DEPTH];

  logic sb, sh, lb, lh, uns, mem_rd, mem_wr;
  assign {sb, sh, lb, lh, uns, mem_rd, mem_wr} = i_ctrl_mem;

  logic [NB_ADDR-1:0] word_idx;
  logic [1:0]         lane;
  assign word_idx = i_alu_result[NB_ADDR+1:2];
  assign lane     = i_alu_result[1:0];

  // A store's size comes from SB/SH, otherwise the load size bits decide.
  logic acc_byte, acc_half, misaligned, wr_en;
  always_comb begin
    acc_byte = 1'b0;
    acc_half = 1'b0;
    if (mem_wr) begin
      acc_byte = sb;
      acc_half = !sb && sh;
    end else begin
      acc_byte = lb;
      acc_half = !lb && lh;
    end
  end

  assign misaligned = (mem_rd || mem_wr) &&
                      ((acc_half && lane[0]) || (!acc_byte && !acc_half && (lane != 2'b00)));
  assign wr_en = i_rst_n && i_valid && !i_stall && mem_wr && !misaligned;

  logic [NB_LANE-1:0] be;
  logic [NB_DATA-1:0] wdata;
  always_comb begin
    be    = '0;
    wdata = i_store_data;
    if (acc_byte) begin
      be[lane] = 1'b1;
      wdata    = {NB_LANE{i_store_data[7:0]}};
    end else if (acc_half) begin
      be    = lane[1] ? 4'b1100 : 4'b0011;
      wdata = {(NB_LANE/2){i_store_data[15:0]}};
    end else begin
      be = '1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int l = 0; l < NB_LANE; l++) begin
        if (be[l]) mem_q[word_idx][l*8 +: 8] <= wdata[l*8 +: 8];
      end
    end
  end

  assign o_debug_data = mem_q[i_debug_addr];

  logic [NB_DATA-1:0] rd_word, rd_shift, load_val;
  assign rd_word  = mem_q[word_idx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    load_val = '0;
    if (mem_rd && !mem_wr && !misaligned) begin
      if (acc_byte)
        load_val = uns ? {{(NB_DATA-8){1'b0}}, rd_shift[7:0]}
                       : {{(NB_DATA-8){rd_shift[7]}}, rd_shift[7:0]};
      else if (acc_half)
        load_val = uns ? {{(NB_DATA-16){1'b0}}, rd_shift[15:0]}
                       : {{(NB_DATA-16){rd_shift[15]}}, rd_shift[15:0]};
      else
        load_val = rd_word;
    end
  end

  logic                  valid_d, valid_q, mis_d, mis_q;
  logic [NB_CTRL_WB-1:0] ctrl_wb_d, ctrl_wb_q;
  logic [NB_DATA-1:0]    read_data_d, read_data_q, alu_d, alu_q;
  logic [NB_REG-1:0]     rd_addr_d, rd_addr_q;

  always_comb begin
    valid_d     = 1'b0;
    ctrl_wb_d   = '0;
    read_data_d = '0;
    alu_d       = '0;
    rd_addr_d   = '0;
    mis_d       = 1'b0;
    if (i_valid) begin
      valid_d     = 1'b1;
      ctrl_wb_d   = i_ctrl_wb;
      read_data_d = load_val;
      alu_d       = i_alu_result;
      rd_addr_d   = i_rd_addr;
      mis_d       = misaligned;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q     <= 1'b0;
      ctrl_wb_q   <= '0;
      read_data_q <= '0;
      alu_q       <= '0;
      rd_addr_q   <= '0;
      mis_q       <= 1'b0;
    end else if (!i_stall) begin
      valid_q     <= valid_d;
      ctrl_wb_q   <= ctrl_wb_d;
      read_data_q <= read_data_d;
      alu_q       <= alu_d;
      rd_addr_q   <= rd_addr_d;
      mis_q       <= mis_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_ctrl_wb    = ctrl_wb_q;
  assign o_read_data  = read_data_q;
  assign o_alu_result = alu_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_misaligned = mis_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Bench for data_mem_stage: byte-array memory model, expected MEM/WB words queued at drive time.
module tb_data_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid, i_stall;
  logic [6:0]  i_ctrl_mem;
  logic [1:0]  i_ctrl_wb;
  logic [31:0] i_alu_result, i_store_data;
  logic [4:0]  i_rd_addr;
  logic [7:0]  i_debug_addr;
  logic        o_valid, o_misaligned;
  logic [1:0]  o_ctrl_wb;
  logic [31:0] o_read_data, o_alu_result, o_debug_data;
  logic [4:0]  o_rd_addr;

  always #5 i_clk = ~i_clk;

  data_mem_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_stall(i_stall),
    .i_ctrl_mem(i_ctrl_mem), .i_ctrl_wb(i_ctrl_wb), .i_alu_result(i_alu_result),
    .i_store_data(i_store_data), .i_rd_addr(i_rd_addr), .i_debug_addr(i_debug_addr),
    .o_valid(o_valid), .o_ctrl_wb(o_ctrl_wb), .o_read_data(o_read_data),
    .o_alu_result(o_alu_result), .o_rd_addr(o_rd_addr), .o_misaligned(o_misaligned),
    .o_debug_data(o_debug_data)
  );

  typedef struct packed {
    logic        vld;
    logic [1:0]  wb;
    logic [31:0] rdat;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        mis;
  } out_t;

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_SW   = 7'b0000001;
  localparam logic [6:0] C_LW   = 7'b0000010;
  localparam logic [6:0] C_RW   = 7'b0000011;
  localparam logic [6:0] C_SB   = 7'b1000001;
  localparam logic [6:0] C_SH   = 7'b0100001;
  localparam logic [6:0] C_LB   = 7'b0010010;
  localparam logic [6:0] C_LBU  = 7'b0010110;
  localparam logic [6:0] C_LH   = 7'b0001010;
  localparam logic [6:0] C_LHU  = 7'b0001110;

  out_t       exp_q[$];
  out_t       last_exp;
  logic [7:0] mdl [1024];
  int         checks = 0;
  int         errors = 0;

  function automatic out_t observed();
    out_t g;
    g.vld = o_valid; g.wb = o_ctrl_wb; g.rdat = o_read_data;
    g.alu = o_alu_result; g.rd = o_rd_addr; g.mis = o_misaligned;
    return g;
  endfunction

  task automatic do_op(input logic [6:0] c, input logic [31:0] a, input logic [31:0] d,
                       input logic v, input logic st, input string nm);
    out_t        e, g;
    int          n, base;
    logic [31:0] val;
    logic        wr, rd, mis;
    @(negedge i_clk);
    i_valid = v; i_stall = st; i_ctrl_mem = c; i_ctrl_wb = {~c[0], c[1]};
    i_alu_result = a; i_store_data = d; i_rd_addr = a[6:2] ^ 5'h15;
    wr = c[0]; rd = c[1];
    if (wr) n = c[6] ? 1 : (c[5] ? 2 : 4);
    else    n = c[4] ? 1 : (c[3] ? 2 : 4);
    mis  = (wr || rd) && ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00));
    base = int'(a[9:0]);
    val  = '0;
    if (rd && !wr && !mis) begin
      for (int k = 0; k < n; k++) val[k*8 +: 8] = mdl[base+k];
      if (!c[2] && n == 1) val = {{24{val[7]}}, val[7:0]};
      if (!c[2] && n == 2) val = {{16{val[15]}}, val[15:0]};
    end
    if (st) e = last_exp;
    else if (!v) e = '0;
    else begin
      e.vld = 1'b1; e.wb = i_ctrl_wb; e.rdat = val; e.alu = a; e.rd = i_rd_addr; e.mis = mis;
    end
    if (v && !st && wr && !mis)
      for (int k = 0; k < n; k++) mdl[base+k] = d[k*8 +: 8];
    last_exp = e;
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    g = observed();
    e = exp_q.pop_front();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, g, e);
    end
  endtask

  task automatic check_dbg(input int idx, input string nm);
    logic [31:0] e;
    i_debug_addr = 8'(idx);
    #1;
    e = {mdl[idx*4+3], mdl[idx*4+2], mdl[idx*4+1], mdl[idx*4]};
    checks++;
    if (o_debug_data !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, o_debug_data, e);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_stall = 1'b0; i_ctrl_mem = '0; i_ctrl_wb = '0;
    i_alu_result = '0; i_store_data = '0; i_rd_addr = '0; i_debug_addr = '0;
    last_exp = '0;
    #12;
    checks++;
    if (observed() !== out_t'(0)) begin
      errors++;
      $display("FAIL reset_state got=%h exp=0", observed());
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_word();
    do_op(C_SW, 32'h10, 32'hDEADBEEF, 1, 0, "sw_10");
    do_op(C_LW, 32'h10, 32'h0, 1, 0, "lw_10");
    check_dbg(4, "dbg_idx4");
  endtask

  task automatic test_byte();
    do_op(C_SW,  32'h20, 32'h0, 1, 0, "sw_20_clear");
    do_op(C_SB,  32'h23, 32'h000000F0, 1, 0, "sb_23");
    check_dbg(8, "dbg_idx8");
    do_op(C_LB,  32'h23, 32'h0, 1, 0, "lb_23");
    do_op(C_LBU, 32'h23, 32'h0, 1, 0, "lbu_23");
    do_op(C_LBU, 32'h20, 32'h0, 1, 0, "lbu_20");
  endtask

  task automatic test_half();
    do_op(C_SW,  32'h30, 32'h0, 1, 0, "sw_30_clear");
    do_op(C_SH,  32'h32, 32'h12348001, 1, 0, "sh_32");
    check_dbg(12, "dbg_idx12");
    do_op(C_LH,  32'h32, 32'h0, 1, 0, "lh_32");
    do_op(C_LHU, 32'h32, 32'h0, 1, 0, "lhu_32");
    do_op(C_LH,  32'h30, 32'h0, 1, 0, "lh_30");
  endtask

  task automatic test_misaligned();
    do_op(C_SW, 32'h40, 32'h11111111, 1, 0, "sw_40");
    do_op(C_SW, 32'h41, 32'h22222222, 1, 0, "sw_41_mis");
    check_dbg(16, "dbg_idx16_unchanged");
    do_op(C_SW, 32'h41, 32'h0, 1, 1, "stall_holds_mis");
    do_op(C_NONE, 32'h12345678, 32'h0, 1, 0, "mis_clears");
    do_op(C_LH, 32'h43, 32'h0, 1, 0, "lh_43_mis");
    do_op(C_LW, 32'h40, 32'h0, 1, 0, "lw_40");
  endtask

  task automatic test_stall_bubble();
    do_op(C_SW, 32'h60, 32'h0, 1, 0, "sw_60_clear");
    for (int i = 0; i < 3; i++) begin
      do_op(C_SW, 32'h60, 32'hCAFEF00D, 1, 1, "stall_hold");
      check_dbg(24, "dbg_stall_nowrite");
    end
    do_op(C_SW, 32'h60, 32'hCAFEF00D, 1, 0, "sw_60_release");
    check_dbg(24, "dbg_idx24");
    do_op(C_LW, 32'h60, 32'h0, 0, 0, "bubble");
    do_op(C_RW, 32'h70, 32'h55AA55AA, 1, 0, "rw_both");
    check_dbg(28, "dbg_idx28");
  endtask

  task automatic test_wrap_reset();
    do_op(C_SW, 32'h400, 32'h0BADF00D, 1, 0, "sw_wrap");
    check_dbg(0, "dbg_idx0_wrap");
    do_op(C_SW, 32'h50, 32'h01020304, 1, 0, "sw_50");
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== out_t'(0)) begin
      errors++;
      $display("FAIL async_reset got=%h exp=0", observed());
    end
    last_exp = '0;
    @(negedge i_clk);
    i_valid = 1'b1; i_stall = 1'b0; i_ctrl_mem = C_SW;
    i_alu_result = 32'h50; i_store_data = 32'hAAAA5555;
    @(posedge i_clk);
    #1;
    check_dbg(20, "store_in_reset_blocked");
    @(negedge i_clk);
    i_valid = 1'b0;
    i_rst_n = 1'b1;
    do_op(C_LW, 32'h50, 32'h0, 1, 0, "lw_50_after_reset");
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_stall_bubble();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
